// File: rtl/relu_stage_pkg.sv
// Shared constants for the activation stage: data width, vector geometry, FSM encodings.
// ACT_CLIP_EN enables the CLIP_MAX upper bound (ReLU-N) in relu_lane.
`ifndef DATA_LEN_MACRO
`define DATA_LEN_MACRO 16
`endif

package relu_stage_pkg;

   localparam int unsigned DATA_LEN  = `DATA_LEN_MACRO;
   localparam int unsigned CHANNELS  = 32;
   localparam int unsigned POSITIONS = 12;
   localparam int unsigned CNT_W     = $clog2(POSITIONS);
   localparam int unsigned VEC_W     = CHANNELS * POSITIONS * DATA_LEN;

`ifdef ACT_CLIP_EN
   localparam logic [DATA_LEN-1:0] CLIP_MAX = DATA_LEN'((1 << (DATA_LEN - 2)) - 1);
`endif

   // Stage states, kept next to the calc-state definitions of the layer pipeline.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } act_state_e;

   typedef logic [CHANNELS-1:0][DATA_LEN-1:0]                 lane_vec_t;
   typedef logic [POSITIONS-1:0][CHANNELS-1:0][DATA_LEN-1:0]  act_vec_t;

endpackage

// File: rtl/relu_lane.sv
// Single-element activation: ReLU (optionally clipped at CLIP_MAX under ACT_CLIP_EN) or pass-through.
module relu_lane
   import relu_stage_pkg::*;
(
   input  logic                en,
   input  logic [DATA_LEN-1:0] d,
   output logic [DATA_LEN-1:0] q
);

   // Sign-bit test only; no arithmetic on the data path.
   always_comb begin
      q = d;
      if (en) begin
         if (d[DATA_LEN-1]) begin
            q = '0;
         end
`ifdef ACT_CLIP_EN
         else if ($signed(d) > $signed(CLIP_MAX)) begin
            q = CLIP_MAX;
         end
`endif
      end
   end

endmodule

// File: rtl/relu_stage.sv
// Captures a 12x32 conv result and activates it one position (32 lanes) per cycle.
// Clipping is enabled by defining ACT_CLIP_EN.
module relu_stage
   import relu_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             relu_en,
   input  logic [VEC_W-1:0] d,
   output logic             valid,
   output logic [VEC_W-1:0] q
);

   act_state_e       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             capture_c;
   logic             write_c;
   logic             relu_q;
   act_vec_t         buf_q;
   act_vec_t         q_r;
   lane_vec_t        lane_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Load is honoured only when no vector is in flight.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      capture_c = 1'b0;
      write_c   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (load) begin
               capture_c = 1'b1;
               cnt_d     = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            write_c = 1'b1;
            if (cnt == CNT_W'(POSITIONS - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q  <= '0;
         relu_q <= 1'b0;
         q_r    <= '0;
      end else if (capture_c) begin
         buf_q  <= d;
         relu_q <= relu_en;
         q_r    <= '0;
      end else if (write_c) begin
         q_r[cnt] <= lane_out;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      relu_lane u_lane (
         .en (relu_q),
         .d  (buf_q[cnt][c]),
         .q  (lane_out[c])
      );
   end

   assign valid = (state == DONE);
   assign q     = q_r;

endmodule

// File: tb/tb_relu_stage.sv
// Self-checking bench for relu_stage: table vectors, scoreboard queue, multi-cycle corner sequences.
module tb_relu_stage;
   import relu_stage_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load;
   logic             relu_en;
   logic [VEC_W-1:0] d;
   logic             valid;
   logic [VEC_W-1:0] q;

   int n_cmp = 0;
   int n_err = 0;
   act_vec_t exp_q[$];

   typedef struct {
      logic [DATA_LEN-1:0] x;
      logic                en;
      logic [DATA_LEN-1:0] exp;
   } vec_rec_t;

   vec_rec_t tbl[9];

   always #5 clk = ~clk;

   relu_stage dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .relu_en (relu_en),
      .d       (d),
      .valid   (valid),
      .q       (q)
   );

   function automatic logic [DATA_LEN-1:0] act_ref(input logic [DATA_LEN-1:0] x, input logic en);
      if (!en) return x;
      if ($signed(x) < 0) return '0;
`ifdef ACT_CLIP_EN
      if (int'($signed(x)) > (1 << (DATA_LEN - 2)) - 1)
         return DATA_LEN'((1 << (DATA_LEN - 2)) - 1);
`endif
      return x;
   endfunction

   function automatic act_vec_t model(input act_vec_t v, input logic en);
      act_vec_t r;
      for (int p = 0; p < POSITIONS; p++)
         for (int c = 0; c < CHANNELS; c++)
            r[p][c] = act_ref(v[p][c], en);
      return r;
   endfunction

   function automatic act_vec_t rand_vec();
      act_vec_t r;
      for (int p = 0; p < POSITIONS; p++)
         for (int c = 0; c < CHANNELS; c++)
            r[p][c] = DATA_LEN'($urandom);
      return r;
   endfunction

   task automatic check_int(input string nm, input int got, input int want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   task automatic check_vec(input string nm, input act_vec_t got, input act_vec_t want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         for (int i = 0; i < CHANNELS * POSITIONS; i++) begin
            if (got[i / CHANNELS][i % CHANNELS] !== want[i / CHANNELS][i % CHANNELS]) begin
               $display("FAIL %s: element %0d got %h expected %h", nm, i,
                        got[i / CHANNELS][i % CHANNELS], want[i / CHANNELS][i % CHANNELS]);
               break;
            end
         end
      end
   endtask

   // Called just after a rising edge; the load is sampled at the next edge.
   task automatic start(input act_vec_t v, input logic en);
      d       = v;
      relu_en = en;
      load    = 1'b1;
      @(posedge clk); #1;
      load    = 1'b0;
      exp_q.push_back(model(v, en));
   endtask

   task automatic wait_valid(input int offset, output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = offset + i;
            break;
         end
      end
   endtask

   task automatic expect_out(input string nm);
      act_vec_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: output with empty scoreboard", nm);
      end else begin
         e = exp_q.pop_front();
         check_vec(nm, act_vec_t'(q), e);
      end
   endtask

   initial begin
      act_vec_t v1, v2, part, qv;
      int lat;

      tbl[0] = '{16'h8000, 1'b1, 16'h0000};
      tbl[1] = '{16'hFFFF, 1'b1, 16'h0000};
      tbl[2] = '{16'h0000, 1'b1, 16'h0000};
      tbl[3] = '{16'h1234, 1'b1, 16'h1234};
`ifdef ACT_CLIP_EN
      tbl[4] = '{16'h7FFF, 1'b1, 16'h3FFF};
      tbl[7] = '{16'h4000, 1'b1, 16'h3FFF};
`else
      tbl[4] = '{16'h7FFF, 1'b1, 16'h7FFF};
      tbl[7] = '{16'h4000, 1'b1, 16'h4000};
`endif
      tbl[5] = '{16'h3FFE, 1'b1, 16'h3FFE};
      tbl[6] = '{16'h8000, 1'b0, 16'h8000};
      tbl[8] = '{16'h3FFF, 1'b1, 16'h3FFF};

      rst_n = 1'b0; load = 1'b0; relu_en = 1'b0; d = '0;
      #1;
      check_int("reset_valid", int'(valid), 0);
      check_vec("reset_q", act_vec_t'(q), '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_int("idle_valid", int'(valid), 0);

      // Table vectors, each value planted at the first, last and one inner element.
      for (int i = 0; i < 9; i++) begin
         v1 = rand_vec();
         v1[0][0] = tbl[i].x;
         v1[POSITIONS-1][CHANNELS-1] = tbl[i].x;
         v1[i % POSITIONS][(i * 7) % CHANNELS] = tbl[i].x;
         start(v1, tbl[i].en);
         wait_valid(0, lat);
         check_int($sformatf("tbl%0d_latency", i), lat, 12);
         qv = q;
         check_int($sformatf("tbl%0d_elem383", i), int'(qv[POSITIONS-1][CHANNELS-1]), int'(tbl[i].exp));
         check_int($sformatf("tbl%0d_elem0", i), int'(qv[0][0]), int'(tbl[i].exp));
         expect_out($sformatf("tbl%0d_vector", i));
      end

      // Mixed signs at fixed elements.
      v1 = rand_vec();
      v1[0][0] = 16'h8000; v1[0][1] = 16'hFFFF; v1[0][2] = 16'h0000; v1[11][31] = 16'h1234;
      start(v1, 1'b1);
      wait_valid(0, lat);
      check_int("mixed_latency", lat, 12);
      qv = q;
      check_int("mixed_e0", int'(qv[0][0]), 0);
      check_int("mixed_e1", int'(qv[0][1]), 0);
      check_int("mixed_e2", int'(qv[0][2]), 0);
      check_int("mixed_e383", int'(qv[11][31]), 16'h1234);
      expect_out("mixed_vector");

      // Pass-through: index values, negated at odd indices; q must equal d and hold.
      for (int i = 0; i < CHANNELS * POSITIONS; i++)
         v1[i / CHANNELS][i % CHANNELS] = (i % 2 == 1) ? DATA_LEN'(-i) : DATA_LEN'(i);
      start(v1, 1'b0);
      wait_valid(0, lat);
      check_int("pass_latency", lat, 12);
      check_vec("pass_bitexact", act_vec_t'(q), v1);
      expect_out("pass_vector");
      repeat (3) @(posedge clk);
      #1;
      check_vec("pass_hold", act_vec_t'(q), v1);
      check_int("pass_hold_valid", int'(valid), 1);

      // Load during RUN cycle 3 is ignored, including its relu_en.
      v1 = rand_vec();
      v2 = rand_vec();
      start(v1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      d = v2; relu_en = 1'b0; load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      wait_valid(3, lat);
      check_int("ignore_latency", lat, 12);
      expect_out("ignore_vector");

      // Back-to-back restart on the first DONE cycle.
      v1 = rand_vec();
      v2 = rand_vec();
      start(v1, 1'b1);
      wait_valid(0, lat);
      check_int("b2b_first_latency", lat, 12);
      expect_out("b2b_first");
      start(v2, 1'b1);
      check_int("b2b_valid_drop", int'(valid), 0);
      check_vec("b2b_cleared", act_vec_t'(q), '0);
      @(posedge clk); #1;
      part = '0;
      part[0] = exp_q[0][0];
      check_vec("b2b_partial", act_vec_t'(q), part);
      wait_valid(1, lat);
      check_int("b2b_second_latency", lat, 12);
      expect_out("b2b_second");

      // Asynchronous reset on the 5th RUN cycle discards the vector.
      v1 = rand_vec();
      start(v1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_int("midrun_reset_valid", int'(valid), 0);
      check_vec("midrun_reset_q", act_vec_t'(q), '0);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_valid(0, lat);
      check_int("no_restart_without_load", lat, -1);
      v1 = rand_vec();
      start(v1, 1'b1);
      wait_valid(0, lat);
      check_int("after_reset_latency", lat, 12);
      expect_out("after_reset_vector");

      check_int("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
